// File: rtl/mrd_fsm_pkt.sv
// -----------------------------------------------------------------------------
// mrd_fsm_pkt
// Shared definitions for the mixed-radix DFT memory engine sequencer:
//   - mrd_state_e : encoding of the 3-bit fsm state bus seen by all engine blocks
//   - RADIX_MIN/MAX : legal range of a radix factor in the Nf list
//   - WDOG_LIMIT : stall limit used when MRD_FSM_WATCHDOG_EN is defined
//   - is_valid_radix() : true for a factor that continues the Nf list
// -----------------------------------------------------------------------------
package mrd_fsm_pkt;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SINK        = 3'd1,
    S_WAIT_TO_RD  = 3'd2,
    S_RD          = 3'd3,
    S_WAIT_WR_END = 3'd4,
    S_SOURCE      = 3'd5
  } mrd_state_e;

  localparam logic [2:0]  RADIX_MIN  = 3'd2;
  localparam logic [2:0]  RADIX_MAX  = 3'd5;
  localparam int          NUM_NF     = 6;
  localparam int          WAIT_CNT_W = 4;
  localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;

  function automatic logic is_valid_radix(input logic [2:0] r);
    return (r >= RADIX_MIN) && (r <= RADIX_MAX);
  endfunction

endpackage

// File: rtl/mrd_stage_count.sv
// -----------------------------------------------------------------------------
// mrd_stage_count
// Combinational count of the leading valid radix factors in the Nf list.
// The first out-of-range factor terminates the list, so the count is the index
// of the first invalid entry, or 6 when all entries are valid.
// Ports:
//   nf    in  [0:5][2:0] radix factors N1..N6 (nf[0] = N1)
//   count out [2:0]      number of leading valid factors (0..6)
// -----------------------------------------------------------------------------
module mrd_stage_count
  import mrd_fsm_pkt::*;
(
  input  logic [0:NUM_NF-1][2:0] nf,
  output logic [2:0]             count
);

  // Scanning from the top down leaves the lowest invalid index in count.
  always_comb begin
    // NOTE: the default assigned before the loop keeps this block free of latches.
    count = 3'(NUM_NF);
    for (int i = NUM_NF - 1; i >= 0; i--) begin
      if (!is_valid_radix(nf[i])) count = 3'(i);
    end
  end

endmodule

// File: rtl/mrd_fsm_ctrl.sv
// -----------------------------------------------------------------------------
// mrd_fsm_ctrl
// Top-level sequencer of the mixed-radix DFT memory engine. Drives the shared
// fsm bus through Idle -> Sink -> (Wait_to_rd -> Rd -> Wait_wr_end) x stages
// -> Source -> Idle, one Rd/write-back pass per leading valid Nf factor.
// Optional feature: define MRD_FSM_WATCHDOG_EN to add a stall watchdog and
// the wdog_err output.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   sink_sop, sink_valid  frame start request (qualified by sink_valid)
//   sink_end, rd_end, wr_end, source_end  one-cycle completion pulses
//   Nf [0:5][2:0]         radix factors N1..N6, latched at frame start
//   fsm, fsm_r            current state and its one-cycle-delayed copy
//   stage_idx             0-based index of the current Rd pass
//   sink_ready            high in Idle and Sink
//   frame_done            pulse on Source -> Idle
//   sop_dropped           pulse the cycle after a qualified sop outside Idle
//   wdog_err              (watchdog build only) pulse when a stall is aborted
// -----------------------------------------------------------------------------
module mrd_fsm_ctrl
  import mrd_fsm_pkt::*;
#(
  parameter int WAIT_RD = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sink_sop,
  input  logic                   sink_valid,
  input  logic                   sink_end,
  input  logic                   rd_end,
  input  logic                   wr_end,
  input  logic                   source_end,
  input  logic [0:NUM_NF-1][2:0] Nf,
  output logic [2:0]             fsm,
  output logic [2:0]             fsm_r,
  output logic [2:0]             stage_idx,
  output logic                   sink_ready,
  output logic                   frame_done,
  output logic                   sop_dropped
`ifdef MRD_FSM_WATCHDOG_EN
  ,
  output logic                   wdog_err
`endif
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_RD - 1);

  mrd_state_e            state_q, state_d;
  logic [2:0]            fsm_r_q;
  logic [2:0]            num_stages_q, num_stages_d;
  logic [2:0]            stage_idx_q, stage_idx_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  pend_q, pend_d;
  logic                  sink_ready_q, sink_ready_d;
  logic                  frame_done_q, frame_done_d;
  logic                  sop_dropped_q, sop_dropped_d;
  logic [2:0]            stage_cnt;
`ifdef MRD_FSM_WATCHDOG_EN
  logic [15:0]           wdog_cnt_q, wdog_cnt_d;
  logic                  wdog_err_q, wdog_err_d;
`endif

  mrd_stage_count u_stage_count (
    .nf    (Nf),
    .count (stage_cnt)
  );

  always_comb begin
    state_d      = state_q;
    num_stages_d = num_stages_q;
    stage_idx_d  = stage_idx_q;
    wait_cnt_d   = '0;
    pend_d       = pend_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sink_sop && sink_valid) begin
          state_d      = S_SINK;
          num_stages_d = stage_cnt;
          stage_idx_d  = '0;
        end
      end
      S_SINK: begin
        if (sink_end) state_d = S_WAIT_TO_RD;
      end
      S_WAIT_TO_RD: begin
        if (num_stages_q == 3'd0) begin
          state_d = S_SOURCE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_RD;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_RD: begin
        if (rd_end) begin
          state_d = S_WAIT_WR_END;
          // Write-back finished together with the reads: remember it so the
          // next state does not wait for a wr_end that already happened.
          if (wr_end) pend_d = 1'b1;
        end
      end
      S_WAIT_WR_END: begin
        pend_d = 1'b0;
        if (wr_end || pend_q) begin
          if (stage_idx_q == num_stages_q - 3'd1) begin
            state_d = S_SOURCE;
          end else begin
            state_d     = S_WAIT_TO_RD;
            stage_idx_d = stage_idx_q + 3'd1;
          end
        end
      end
      S_SOURCE: begin
        if (source_end) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;  // codes 6/7 recover to Idle
    endcase

    // Any state other than Idle rejects a new frame, including the Source
    // cycle in which source_end arrives.
    sop_dropped_d = sink_sop && sink_valid && (state_q != S_IDLE);

`ifdef MRD_FSM_WATCHDOG_EN
    wdog_err_d = 1'b0;
    wdog_cnt_d = (state_d != state_q) ? 16'd0 : wdog_cnt_q + 16'd1;
    if ((wdog_cnt_q == WDOG_LIMIT) &&
        ((state_q == S_SINK) || (state_q == S_RD) ||
         (state_q == S_WAIT_WR_END) || (state_q == S_SOURCE))) begin
      state_d      = S_IDLE;
      wdog_err_d   = 1'b1;
      wdog_cnt_d   = 16'd0;
      pend_d       = 1'b0;
      frame_done_d = 1'b0;
    end
`endif

    // Registered from the next state so it falls together with leaving Sink.
    sink_ready_d = (state_d == S_IDLE) || (state_d == S_SINK);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it is sampled only at the clock edge and
    // overrides every pulse input of that cycle.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      fsm_r_q       <= 3'd0;
      num_stages_q  <= 3'd0;
      stage_idx_q   <= 3'd0;
      wait_cnt_q    <= '0;
      pend_q        <= 1'b0;
      sink_ready_q  <= 1'b1;
      frame_done_q  <= 1'b0;
      sop_dropped_q <= 1'b0;
`ifdef MRD_FSM_WATCHDOG_EN
      wdog_cnt_q    <= 16'd0;
      wdog_err_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      fsm_r_q       <= state_q;
      num_stages_q  <= num_stages_d;
      stage_idx_q   <= stage_idx_d;
      wait_cnt_q    <= wait_cnt_d;
      pend_q        <= pend_d;
      sink_ready_q  <= sink_ready_d;
      frame_done_q  <= frame_done_d;
      sop_dropped_q <= sop_dropped_d;
`ifdef MRD_FSM_WATCHDOG_EN
      wdog_cnt_q    <= wdog_cnt_d;
      wdog_err_q    <= wdog_err_d;
`endif
    end
  end

  assign fsm         = state_q;
  assign fsm_r       = fsm_r_q;
  assign stage_idx   = stage_idx_q;
  assign sink_ready  = sink_ready_q;
  assign frame_done  = frame_done_q;
  assign sop_dropped = sop_dropped_q;
`ifdef MRD_FSM_WATCHDOG_EN
  assign wdog_err    = wdog_err_q;
`endif

endmodule
